// File: rtl/cordic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cordic_phase_sequencer
// Brief    : Issues a phase-accumulated angle stream to a CORDIC core, one
//            request outstanding at a time, with stop, count and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_phase_sequencer #(
   parameter int INT_ANGLE_WIDTH = 32,
   parameter int CNT_WIDTH       = 16,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_start,
   input  logic                       i_stop,
   input  logic [INT_ANGLE_WIDTH-1:0] i_phase_step,
   input  logic [INT_ANGLE_WIDTH-1:0] i_phase_offset,
   input  logic [CNT_WIDTH-1:0]       i_sample_cnt,
   input  logic                       i_cordic_valid,
   output logic                       o_valid,
   output logic [INT_ANGLE_WIDTH-1:0] o_target_angle,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_timeout,
   output logic [CNT_WIDTH-1:0]       o_issued_cnt
);

   localparam int c_TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TIMER_WIDTH-1:0] c_TIMER_LAST = c_TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [c_TIMER_WIDTH-1:0] c_TIMER_ONE  = c_TIMER_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]     c_CNT_ONE    = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                     r_state;
   logic [INT_ANGLE_WIDTH-1:0] r_step;
   logic [INT_ANGLE_WIDTH-1:0] r_offset;
   logic [CNT_WIDTH-1:0]       r_count;
   logic [INT_ANGLE_WIDTH-1:0] r_acc;
   logic [c_TIMER_WIDTH-1:0]   r_timer;
   logic                       r_stop_pending;

   logic [INT_ANGLE_WIDTH-1:0] w_acc_next;
   logic [CNT_WIDTH-1:0]       w_cnt_next;
   logic                       w_last_sample;
   logic                       w_finish;
   logic                       w_timer_expired;

   assign w_acc_next      = r_acc + r_step;
   assign w_cnt_next      = o_issued_cnt + c_CNT_ONE;
   assign w_last_sample   = (r_count != '0) && (w_cnt_next == r_count);
   // A stop arriving together with the result still ends the run after it.
   assign w_finish        = w_last_sample || r_stop_pending || i_stop;
   assign w_timer_expired = (r_timer == c_TIMER_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_step         <= '0;
         r_offset       <= '0;
         r_count        <= '0;
         r_acc          <= '0;
         r_timer        <= '0;
         r_stop_pending <= 1'b0;
         o_valid        <= 1'b0;
         o_target_angle <= '0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_timeout      <= 1'b0;
         o_issued_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               o_valid        <= 1'b0;
               o_done         <= 1'b0;
               o_busy         <= 1'b0;
               r_stop_pending <= 1'b0;
               r_timer        <= '0;
               if (i_start) begin
                  r_step         <= i_phase_step;
                  r_offset       <= i_phase_offset;
                  r_count        <= i_sample_cnt;
                  r_acc          <= '0;
                  o_issued_cnt   <= '0;
                  o_timeout      <= 1'b0;
                  o_target_angle <= i_phase_offset;
                  o_valid        <= 1'b1;
                  o_busy         <= 1'b1;
                  r_state        <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               o_valid <= 1'b0;
               r_timer <= '0;
               if (i_stop) begin
                  r_stop_pending <= 1'b1;
               end
               r_state <= ST_WAIT;
            end

            ST_WAIT: begin
               if (i_cordic_valid) begin
                  r_acc        <= w_acc_next;
                  o_issued_cnt <= w_cnt_next;
                  r_timer      <= '0;
                  if (w_finish) begin
                     o_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     o_valid        <= 1'b1;
                     o_target_angle <= w_acc_next + r_offset;
                     r_state        <= ST_ISSUE;
                  end
               end else if (w_timer_expired) begin
                  o_timeout <= 1'b1;
                  o_busy    <= 1'b0;
                  r_timer   <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + c_TIMER_ONE;
                  if (i_stop) begin
                     r_stop_pending <= 1'b1;
                  end
               end
            end

            ST_DONE: begin
               o_done  <= 1'b0;
               o_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_phase_sequencer
// Brief    : Self-checking bench; the bench acts as the CORDIC core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_phase_sequencer;

   localparam int AW = 32;
   localparam int CW = 16;
   localparam int TO = 64;

   logic          clk;
   logic          rst;
   logic          i_start;
   logic          i_stop;
   logic [AW-1:0] i_phase_step;
   logic [AW-1:0] i_phase_offset;
   logic [CW-1:0] i_sample_cnt;
   logic          i_cordic_valid;
   logic          o_valid;
   logic [AW-1:0] o_target_angle;
   logic          o_busy;
   logic          o_done;
   logic          o_timeout;
   logic [CW-1:0] o_issued_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   cordic_phase_sequencer #(
      .INT_ANGLE_WIDTH (AW),
      .CNT_WIDTH       (CW),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (i_start),
      .i_stop         (i_stop),
      .i_phase_step   (i_phase_step),
      .i_phase_offset (i_phase_offset),
      .i_sample_cnt   (i_sample_cnt),
      .i_cordic_valid (i_cordic_valid),
      .o_valid        (o_valid),
      .o_target_angle (o_target_angle),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_timeout      (o_timeout),
      .o_issued_cnt   (o_issued_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // delay = cycles from strobe to result (0 = never answer);
   // stop_at = strobe index during whose wait i_stop is pulsed (0 = none).
   typedef struct {
      logic [AW-1:0] step;
      logic [AW-1:0] offset;
      logic [CW-1:0] count;
      int            delay;
      int            stop_at;
      bit            stop_wr;
      bit            spam;
      bit            glitch;
      int            exp_strobes;
      int            exp_issued;
      int            exp_done;
      bit            exp_timeout;
      logic [AW-1:0] exp_last;
   } vec_t;

   vec_t tbl[9];
   vec_t rv;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Run-level outcome from the sequencing rules: n results, angles offset + k*step.
   function automatic vec_t apply_model(input vec_t v);
      vec_t r;
      int   n;
      r = v;
      if (v.delay == 0) begin
         n             = 1;
         r.exp_issued  = 0;
         r.exp_done    = 0;
         r.exp_timeout = 1'b1;
      end else begin
         if (v.count == '0)
            n = v.stop_at;
         else if (v.stop_at != 0 && v.stop_at < int'(v.count))
            n = v.stop_at;
         else
            n = int'(v.count);
         r.exp_issued  = n;
         r.exp_done    = 1;
         r.exp_timeout = 1'b0;
      end
      r.exp_strobes = n;
      r.exp_last    = v.offset + v.step * 32'(n - 1);
      return r;
   endfunction

   function automatic vec_t make_random();
      vec_t v;
      v.step    = $urandom;
      v.offset  = $urandom;
      v.count   = 16'($urandom_range(0, 6));
      v.delay   = $urandom_range(1, 6);
      v.stop_wr = 1'($urandom_range(0, 1));
      v.spam    = 1'($urandom_range(0, 1));
      v.glitch  = 1'($urandom_range(0, 1));
      if (v.count == '0)
         v.stop_at = $urandom_range(1, 6);
      else if ($urandom_range(0, 1) == 1)
         v.stop_at = $urandom_range(1, int'(v.count) + 1);
      else
         v.stop_at = 0;
      return apply_model(v);
   endfunction

   task automatic run_case(input vec_t v);
      int            n_strobe, strobe_cyc, res_cyc, start_cyc, countdown, budget, done_seen;
      bit            ended, to_seen;
      logic [AW-1:0] hold, ea;
      n_strobe = 0; strobe_cyc = 0; res_cyc = 0; countdown = 0;
      budget = 0; done_seen = 0; ended = 1'b0; to_seen = 1'b0; hold = '0;
      @(negedge clk);
      i_phase_step   = v.step;
      i_phase_offset = v.offset;
      i_sample_cnt   = v.count;
      i_start        = 1'b1;
      start_cyc      = cyc;
      while (!ended && budget < 2000) begin
         @(negedge clk);
         budget++;
         i_start = 1'b0; i_stop = 1'b0; i_cordic_valid = 1'b0;
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               i_cordic_valid = 1'b1;
               res_cyc        = cyc;
               if (v.stop_wr && v.stop_at != 0 && v.stop_at == n_strobe) i_stop = 1'b1;
            end
         end
         if (!v.stop_wr && v.stop_at != 0 && v.stop_at == n_strobe && cyc == strobe_cyc + 1)
            i_stop = 1'b1;
         if (o_done) begin
            done_seen++;
            ended = 1'b1;
            chk("done_latency", cyc, res_cyc + 1);
         end
         if (o_timeout) begin
            to_seen = 1'b1;
            ended   = 1'b1;
            chk("timeout_latency", cyc - strobe_cyc, TO + 1);
         end
         chk("busy", o_busy, !to_seen);
         if (o_valid) begin
            ea = v.offset + v.step * 32'(n_strobe);
            chk("strobe_angle", o_target_angle, ea);
            if (n_strobe == 0) begin
               chk("start_latency", cyc, start_cyc + 1);
               chk("timeout_cleared", o_timeout, 0);
            end else begin
               chk("strobe_gap", (cyc - strobe_cyc) >= 2, 1);
               chk("issue_latency", cyc, res_cyc + 1);
            end
            n_strobe++;
            strobe_cyc = cyc;
            hold       = ea;
            if (v.delay != 0) countdown = v.delay;
            if (v.glitch) i_cordic_valid = 1'b1;
         end else if (n_strobe > 0) begin
            chk("angle_hold", o_target_angle, hold);
         end
         if (v.spam && o_busy && !o_done) begin
            i_start        = 1'b1;
            i_phase_step   = $urandom;
            i_phase_offset = $urandom;
            i_sample_cnt   = 16'($urandom);
         end
         if (v.glitch && ended) i_cordic_valid = 1'b1;
      end
      chk("run_ended", ended, 1);
      chk("strobe_count", n_strobe, v.exp_strobes);
      chk("issued_cnt", o_issued_cnt, v.exp_issued);
      chk("done_pulses", done_seen, v.exp_done);
      chk("timeout_flag", o_timeout, v.exp_timeout);
      chk("last_angle", o_target_angle, v.exp_last);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         i_start = 1'b0; i_stop = 1'b0; i_cordic_valid = 1'b0;
         chk("idle_valid", o_valid, 0);
         chk("idle_done", o_done, 0);
         chk("idle_busy", o_busy, 0);
         chk("idle_timeout", o_timeout, v.exp_timeout);
         chk("idle_issued", o_issued_cnt, v.exp_issued);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_angle"}, o_target_angle, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_timeout"}, o_timeout, 0);
      chk({tag, "_issued"}, o_issued_cnt, 0);
   endtask

   initial begin
      //             step          offset        cnt    dly stop wr spam gl  strb iss done to   last
      tbl[0] = '{32'h01000000, 32'h00000000, 16'd4,  3, 0, 1'b0, 1'b0, 1'b0, 4, 4, 1, 1'b0, 32'h03000000};
      tbl[1] = '{32'h40000000, 32'hC0000000, 16'd3,  2, 0, 1'b0, 1'b0, 1'b0, 3, 3, 1, 1'b0, 32'h40000000};
      tbl[2] = '{32'h00100000, 32'h12345678, 16'd0,  4, 5, 1'b0, 1'b0, 1'b0, 5, 5, 1, 1'b0, 32'h12745678};
      tbl[3] = '{32'h11111111, 32'h00000000, 16'd0,  3, 2, 1'b1, 1'b0, 1'b0, 2, 2, 1, 1'b0, 32'h11111111};
      tbl[4] = '{32'h00000005, 32'h00000007, 16'd3,  0, 0, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b1, 32'h00000007};
      tbl[5] = '{32'h20000000, 32'h10000000, 16'd5,  2, 0, 1'b0, 1'b1, 1'b0, 5, 5, 1, 1'b0, 32'h90000000};
      tbl[6] = '{32'h80000000, 32'h00000001, 16'd2, 64, 0, 1'b0, 1'b0, 1'b0, 2, 2, 1, 1'b0, 32'h80000001};
      tbl[7] = '{32'hFFFFFFFF, 32'h00000000, 16'd3,  1, 0, 1'b0, 1'b0, 1'b1, 3, 3, 1, 1'b0, 32'hFFFFFFFE};
      tbl[8] = '{32'h00000009, 32'h00000003, 16'd1,  5, 1, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b0, 32'h00000003};

      rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_cordic_valid = 1'b0;
      i_phase_step = '0; i_phase_offset = '0; i_sample_cnt = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // A stop while idle must not shorten the following run.
      @(negedge clk);
      i_stop = 1'b1;
      @(negedge clk);
      i_stop = 1'b0;

      for (int i = 0; i < 9; i++) run_case(tbl[i]);

      // Reset in the middle of a wait, followed by a stale CORDIC result.
      @(negedge clk);
      i_phase_step = 32'h00000100; i_phase_offset = 32'h00000055; i_sample_cnt = 16'd3;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("rw_first_valid", o_valid, 1);
      @(negedge clk);
      chk("rw_busy", o_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("rw_reset");
      i_cordic_valid = 1'b1;
      @(negedge clk);
      i_cordic_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_all_zero("rw_after");
         @(negedge clk);
      end

      for (int i = 0; i < 24; i++) begin
         rv = make_random();
         run_case(rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cordic_phase_sequencer.md
CORDIC_PHASE_SEQUENCER -- requirements
Module: cordic_phase_sequencer

Interface
REQ-001 SHALL have parameter INT_ANGLE_WIDTH, default 32, angle word width; full scale 2^INT_ANGLE_WIDTH = 360 degrees.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of sample counters.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum wait for a CORDIC result.
REQ-004 SHALL use one clock and a reset that is synchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 i_start  in  1  single-cycle run request.
REQ-008 i_stop  in  1  request graceful end of run.
REQ-009 i_phase_step  in  INT_ANGLE_WIDTH  phase increment per sample, unsigned modulo.
REQ-010 i_phase_offset  in  INT_ANGLE_WIDTH  constant phase added to every angle.
REQ-011 i_sample_cnt  in  CNT_WIDTH  samples per run; 0 = continuous.
REQ-012 i_cordic_valid  in  1  result strobe, driven by the CORDIC o_valid.
REQ-013 o_valid  out  1  angle strobe, drives the CORDIC i_valid.
REQ-014 o_target_angle  out  INT_ANGLE_WIDTH  angle to the CORDIC i_target_angle, two's-complement interpretation.
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_done  out  1  single-cycle pulse at normal run end.
REQ-017 o_timeout  out  1  sticky flag: CORDIC failed to answer.
REQ-018 o_issued_cnt  out  CNT_WIDTH  completed samples in the current or last run.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-020 IDLE: on i_start, latch step, offset and count; clear accumulator, o_issued_cnt and o_timeout; go to ISSUE.
REQ-021 ISSUE: assert o_valid for exactly one cycle; o_target_angle = accumulator + offset, modulo 2^INT_ANGLE_WIDTH; go to WAIT.
REQ-022 o_valid SHALL rise on the first clock edge after i_start is sampled; latency from start to first angle is 1 cycle.
REQ-023 o_target_angle SHALL stay stable from its o_valid until the next o_valid or reset.
REQ-024 WAIT: increment the timeout timer each cycle and ignore further strobes until i_cordic_valid is sampled.
REQ-025 WAIT with i_cordic_valid: accumulator += step (wrap, no saturation), o_issued_cnt += 1, clear the timer.
REQ-026 From WAIT, go to DONE if the count is non-zero and the new o_issued_cnt equals it, or if a stop is pending; otherwise go to ISSUE.
REQ-027 Consecutive o_valid pulses SHALL be at least 2 cycles apart; only one request is outstanding at any time.
REQ-028 If the timer reaches TIMEOUT_CYCLES without i_cordic_valid: set o_timeout, go to IDLE, and do not pulse o_done.
REQ-029 DONE: pulse o_done for one cycle, then go to IDLE; o_issued_cnt holds its final value.
REQ-030 i_stop in ISSUE or WAIT SHALL set stop_pending; the outstanding result is still awaited; stop_pending clears in IDLE.
REQ-031 i_stop in IDLE SHALL be ignored.
REQ-032 i_start while o_busy SHALL be ignored; latched parameters are unchanged mid-run.
REQ-033 i_cordic_valid in IDLE, ISSUE or DONE SHALL be ignored.
REQ-034 Continuous mode (count 0): o_issued_cnt wraps modulo 2^CNT_WIDTH and the run ends only on stop or timeout.
REQ-035 Simultaneous i_stop and i_cordic_valid in WAIT: count the sample, then go to DONE.

Reset
REQ-036 rst SHALL force state IDLE and set o_valid=0, o_target_angle=0, o_busy=0, o_done=0, o_timeout=0, o_issued_cnt=0, accumulator=0, timer=0, stop_pending=0.
REQ-037 rst asserted mid-run (any state) SHALL take effect at the next edge, with no o_done and no further o_valid.
REQ-038 A CORDIC result arriving after reset SHALL be ignored.

Verification
REQ-039 Step 0x01000000, offset 0, count 4, CORDIC answering 3 cycles after each strobe -> angles 0x00000000, 0x01000000, 0x02000000, 0x03000000; then one o_done pulse; o_issued_cnt=4.
REQ-040 Wrap-around: step 0x40000000, offset 0xC0000000, count 3 -> angles 0xC0000000, 0x00000000, 0x40000000; no extra strobe.
REQ-041 Count 0, i_stop asserted during the 5th WAIT -> 5th result accepted; o_done; o_issued_cnt=5; no 6th o_valid.
REQ-042 No i_cordic_valid after the first strobe -> o_timeout=1 at 64 cycles; state IDLE; o_done stays 0; next i_start clears o_timeout.
REQ-043 i_start repeated during a run -> ignored, angle sequence unaffected; rst during WAIT, then a late i_cordic_valid -> all outputs 0, no o_valid.
REQ-044 Simultaneous i_stop and i_cordic_valid in WAIT -> o_issued_cnt incremented, o_done on the next cycle.
